// File: rtl/rec_sched_pkg.sv
// Shared types and field widths for the record write scheduler.
`default_nettype none

package rec_sched_pkg;

   localparam int BYTE_W  = 8;
   localparam int LEN_W   = 2;
   localparam int STAT_W  = 16;
   localparam int ERR_BIT = 15;
   localparam int DATA_W  = (1 << LEN_W) * BYTE_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
`default_nettype none

module rr_arbiter
   import rec_sched_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            advance_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  idx_o,
   output logic            valid_o
);

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;
   logic [IDW-1:0] cand;
   int             c;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      c       = 0;
      for (int i = 0; i < NREQ; i++) begin
         c = int'(ptr_q) + i;
         if (c >= NREQ) begin
            c = c - NREQ;
         end
         cand = IDW'(c);
         if (!valid_o && req_i[cand]) begin
            valid_o       = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

   assign ptr_d = (idx_o == IDW'(NREQ - 1)) ? '0 : idx_o + IDW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance_i && valid_o) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rec_write_sched.sv
// Serialises byte-range write commands from several requesters into a packed
// record {a, b}, one byte per cycle, with a command counter and sticky range error.
`default_nettype none

module rec_write_sched
   import rec_sched_pkg::*;
#(
   parameter  int NBYTES = 6,
   parameter  int NREQ   = 2,
   localparam int IW     = $clog2(NBYTES),
   localparam int IDW    = id_width(NREQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NREQ-1:0]                req_valid_i,
   output logic [NREQ-1:0]                req_ready_o,
   input  logic [NREQ*IW-1:0]             req_idx_i,
   input  logic [NREQ*LEN_W-1:0]          req_len_i,
   input  logic [NREQ*DATA_W-1:0]         req_data_i,
   output logic [NBYTES*BYTE_W+STAT_W-1:0] rec_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [IDW-1:0]                 done_id_o
);

   typedef struct packed {
      logic [NBYTES-1:0][BYTE_W-1:0] a;
      logic [STAT_W-1:0]             b;
   } rec_t;

   state_t              state_q;
   rec_t                rec_q;
   logic [IW-1:0]       idx_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    k_q;
   logic [DATA_W-1:0]   data_q;
   logic [IDW-1:0]      gnt_q;
   logic                done_q;
   logic [IDW-1:0]      done_id_q;

   logic [NREQ-1:0]     arb_grant;
   logic [IDW-1:0]      arb_idx;
   logic                arb_valid;
   logic                accept;

   logic [IW-1:0]       sel_idx;
   logic [LEN_W-1:0]    sel_len;
   logic [DATA_W-1:0]   sel_data;

   logic [IW+1:0]       wr_addr;
   logic                wr_in_range;
   logic [BYTE_W-1:0]   wr_byte;
   logic                last_byte;
   logic [STAT_W-2:0]   cnt_d;

   assign accept = (state_q == IDLE) && arb_valid;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_valid_i),
      .advance_i (accept),
      .grant_o   (arb_grant),
      .idx_o     (arb_idx),
      .valid_o   (arb_valid)
   );

   always_comb begin
      sel_idx  = '0;
      sel_len  = '0;
      sel_data = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (arb_grant[r]) begin
            sel_idx  = req_idx_i[r*IW +: IW];
            sel_len  = req_len_i[r*LEN_W +: LEN_W];
            sel_data = req_data_i[r*DATA_W +: DATA_W];
         end
      end
   end

   // Address is widened by two bits so idx+k past the end is detected, never wrapped.
   assign wr_addr     = (IW+2)'(idx_q) + (IW+2)'(k_q);
   assign wr_in_range = wr_addr < (IW+2)'(NBYTES);
   assign wr_byte     = data_q[{k_q, 3'b000} +: BYTE_W];
   assign last_byte   = (k_q == len_q);
   assign cnt_d       = rec_q.b[STAT_W-2:0] + (STAT_W-1)'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rec_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         k_q       <= '0;
         data_q    <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  idx_q   <= sel_idx;
                  len_q   <= sel_len;
                  data_q  <= sel_data;
                  gnt_q   <= arb_idx;
                  k_q     <= '0;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (wr_in_range) begin
                  rec_q.a[wr_addr[IW-1:0]] <= wr_byte;
               end else begin
                  rec_q.b[ERR_BIT] <= 1'b1;
               end
               if (last_byte) begin
                  rec_q.b[STAT_W-2:0] <= cnt_d;
                  done_q              <= 1'b1;
                  done_id_q           <= gnt_q;
                  state_q             <= DONE;
               end else begin
                  k_q <= k_q + LEN_W'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = (state_q == IDLE) ? arb_grant : '0;
   assign busy_o      = (state_q == WRITE) || (state_q == DONE);
   assign done_o      = done_q;
   assign done_id_o   = done_id_q;
   assign rec_o       = rec_q;

endmodule

`default_nettype wire

// File: tb/tb_rec_write_sched.sv
// Directed bench for rec_write_sched with NBYTES=6, NREQ=2.
`default_nettype none

module tb_rec_write_sched;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [5:0]  req_idx;
   logic [3:0]  req_len;
   logic [63:0] req_data;
   logic [63:0] rec;
   logic        busy;
   logic        done;
   logic [0:0]  done_id;

   int checks = 0;
   int errors = 0;
   int alt_err = 0;

   rec_write_sched #(
      .NBYTES (6),
      .NREQ   (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_idx_i   (req_idx),
      .req_len_i   (req_len),
      .req_data_i  (req_data),
      .rec_o       (rec),
      .busy_o      (busy),
      .done_o      (done),
      .done_id_o   (done_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic v, input logic [2:0] idx,
                          input logic [1:0] len, input logic [31:0] d);
      req_valid[r]         = v;
      req_idx[r*3 +: 3]    = idx;
      req_len[r*2 +: 2]    = len;
      req_data[r*32 +: 32] = d;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_idx   = '0;
      req_len   = '0;
      req_data  = '0;

      // Reset state
      step();
      step();
      chk("rst_rec", rec, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_ready", {62'h0, req_ready}, 64'h0);

      // Single two-byte command from requester 0
      rst_n = 1'b1;
      set_req(0, 1'b1, 3'd1, 2'd1, 32'h0000_1234);
      #1;
      chk("t2_ready_accept", {62'h0, req_ready}, 64'h1);
      step();
      req_valid = '0;
      #1;
      chk("t2_ready_write", {62'h0, req_ready}, 64'h0);
      chk("t2_busy", {63'h0, busy}, 64'h1);
      step();
      chk("t2_done_early", {63'h0, done}, 64'h0);
      step();
      chk("t2_done", {63'h0, done}, 64'h1);
      chk("t2_done_id", {63'h0, done_id}, 64'h0);
      chk("t2_rec", rec, 64'h0000_0012_3400_0001);
      step();
      chk("t2_done_pulse", {63'h0, done}, 64'h0);
      chk("t2_busy_idle", {63'h0, busy}, 64'h0);

      // Both requesters valid from reset: round-robin order
      rst_n = 1'b0;
      set_req(0, 1'b1, 3'd5, 2'd0, 32'h0000_0042);
      set_req(1, 1'b1, 3'd0, 2'd0, 32'h0000_00FC);
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("t3_ready_r0", {62'h0, req_ready}, 64'h1);
      step();
      step();
      chk("t3_done_r0", {63'h0, done}, 64'h1);
      chk("t3_id_r0", {63'h0, done_id}, 64'h0);
      step();
      #1;
      chk("t3_ready_r1", {62'h0, req_ready}, 64'h2);
      step();
      req_valid = '0;
      step();
      chk("t3_done_r1", {63'h0, done}, 64'h1);
      chk("t3_id_r1", {63'h0, done_id}, 64'h1);
      chk("t3_rec", rec, 64'h4200_0000_00FC_0002);
      step();

      // Out-of-range bytes dropped, sticky error
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      set_req(0, 1'b1, 3'd5, 2'd3, 32'hAABB_CC42);
      step();
      req_valid = '0;
      step();
      step();
      step();
      step();
      chk("t4_done", {63'h0, done}, 64'h1);
      chk("t4_rec", rec, 64'h4200_0000_0000_8001);
      step();
      set_req(1, 1'b1, 3'd0, 2'd0, 32'h0000_0011);
      #1;
      chk("t4_ready_r1", {62'h0, req_ready}, 64'h2);
      step();
      req_valid = '0;
      step();
      chk("t4_done_id", {63'h0, done_id}, 64'h1);
      chk("t4_rec_sticky", rec, 64'h4200_0000_0011_8002);
      step();

      // Reset in the middle of a command
      set_req(0, 1'b1, 3'd0, 2'd3, 32'h0403_0201);
      #1;
      chk("t5_ready", {62'h0, req_ready}, 64'h1);
      step();
      req_valid = '0;
      step();
      chk("t5_partial", rec, 64'h4200_0000_0001_8002);
      rst_n = 1'b0;
      step();
      chk("t5_rec", rec, 64'h0);
      chk("t5_busy", {63'h0, busy}, 64'h0);
      chk("t5_done", {63'h0, done}, 64'h0);
      rst_n = 1'b1;
      step();
      step();
      step();
      chk("t5_no_done", {63'h0, done}, 64'h0);
      chk("t5_rec_after", rec, 64'h0);

      // Command counter wrap with alternating grants
      set_req(0, 1'b1, 3'd0, 2'd0, 32'h0000_00A5);
      set_req(1, 1'b1, 3'd1, 2'd0, 32'h0000_005A);
      for (int n = 0; n < 32768; n++) begin
         #1;
         if (req_ready !== (n[0] ? 2'b10 : 2'b01)) alt_err++;
         step();
         step();
         if (done !== 1'b1 || done_id !== n[0]) alt_err++;
         if (n == 32766) chk("t6_cnt_max", {48'h0, rec[15:0]}, 64'h7FFF);
         step();
      end
      chk("t6_alternation", 64'(alt_err), 64'h0);
      chk("t6_rec_wrap", rec, 64'h0000_0000_5AA5_0000);
      req_valid = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
